// File: rtl/pcie_flr_responder.sv
// FLR responder: queues VF FLR strobes, services them one at a time with a held reset and paced completion strobe.
// Per-PF trackers pulse pf_rst_n on FLR-active rise and hold a completion level until the request drops.
module pcie_flr_responder #(
  parameter int NUM_PF      = 1,
  parameter int PF_WIDTH    = 1,
  parameter int VF_WIDTH    = 11,
  parameter int FIFO_DEPTH  = 4,
  parameter int RST_HOLD    = 16,
  parameter int CPL_GAP     = 32,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                fim_clk,
  input  logic                fim_rst_n,
  input  logic                flr_rcvd_vf,
  input  logic [PF_WIDTH-1:0] flr_rcvd_pf_num,
  input  logic [VF_WIDTH-1:0] flr_rcvd_vf_num,
  input  logic [NUM_PF-1:0]   flr_active_pf,
  output logic                vf_rst_req,
  output logic [PF_WIDTH-1:0] vf_rst_pf_num,
  output logic [VF_WIDTH-1:0] vf_rst_vf_num,
  input  logic                vf_rst_ack,
  output logic [NUM_PF-1:0]   pf_rst_n,
  output logic                flr_completed_vf,
  output logic [PF_WIDTH-1:0] flr_completed_pf_num,
  output logic [VF_WIDTH-1:0] flr_completed_vf_num,
  output logic [NUM_PF-1:0]   flr_completed_pf,
  output logic                flr_ovf_err,
  output logic                flr_ack_timeout_err
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int VMAX   = (ACK_TIMEOUT > RST_HOLD) ?
                          ((ACK_TIMEOUT > CPL_GAP) ? ACK_TIMEOUT : CPL_GAP) :
                          ((RST_HOLD > CPL_GAP) ? RST_HOLD : CPL_GAP);
  localparam int VCNT_W = $clog2(VMAX + 1);
  localparam int PCNT_W = $clog2(RST_HOLD + 1);

  typedef struct packed {
    logic [PF_WIDTH-1:0] pf;
    logic [VF_WIDTH-1:0] vf;
  } flr_ent_t;

  typedef enum logic [2:0] {VF_IDLE, VF_REQ, VF_HOLD, VF_CPL, VF_GAP} vf_state_e;
  typedef enum logic [1:0] {PF_IDLE, PF_RST, PF_DONE} pf_state_e;

  flr_ent_t          fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              fifo_empty, fifo_full, push, pop;

  vf_state_e         vf_st_q, vf_st_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  flr_ent_t          req_q, cpl_q;
  logic              load_cpl, to_set;
  logic              ovf_q, to_q;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == FCNT_W'(FIFO_DEPTH));
  // A full queue still accepts a strobe when the head leaves in the same cycle.
  assign push       = flr_rcvd_vf && (!fifo_full || pop);

  always_ff @(posedge fim_clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pf: flr_rcvd_pf_num, vf: flr_rcvd_vf_num};
  end

  always_comb begin
    vf_st_d  = vf_st_q;
    vcnt_d   = vcnt_q;
    pop      = 1'b0;
    load_cpl = 1'b0;
    to_set   = 1'b0;
    case (vf_st_q)
      VF_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        vf_st_d = VF_REQ;
        vcnt_d  = '0;
      end
      VF_REQ: if (vf_rst_ack) begin
        vf_st_d = VF_HOLD;
        vcnt_d  = '0;
      end else if (vcnt_q == VCNT_W'(ACK_TIMEOUT - 1)) begin
        vf_st_d = VF_HOLD;
        vcnt_d  = '0;
        to_set  = 1'b1;
      end else begin
        vcnt_d = vcnt_q + VCNT_W'(1);
      end
      VF_HOLD: if (vcnt_q == VCNT_W'(RST_HOLD - 1)) begin
        vf_st_d  = VF_CPL;
        load_cpl = 1'b1;
      end else begin
        vcnt_d = vcnt_q + VCNT_W'(1);
      end
      VF_CPL: begin
        vf_st_d = VF_GAP;
        vcnt_d  = '0;
      end
      VF_GAP: if (vcnt_q == VCNT_W'(CPL_GAP - 1)) begin
        vf_st_d = VF_IDLE;
      end else begin
        vcnt_d = vcnt_q + VCNT_W'(1);
      end
      default: vf_st_d = VF_IDLE;
    endcase
  end

  always_ff @(posedge fim_clk or negedge fim_rst_n) begin
    if (!fim_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      vf_st_q  <= VF_IDLE;
      vcnt_q   <= '0;
      req_q    <= '0;
      cpl_q    <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      vf_st_q <= vf_st_d;
      vcnt_q  <= vcnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        req_q    <= fifo_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (load_cpl) cpl_q <= req_q;
      if (flr_rcvd_vf && !push) ovf_q <= 1'b1;
      if (to_set) to_q <= 1'b1;
    end
  end

  assign vf_rst_req           = (vf_st_q == VF_REQ);
  assign vf_rst_pf_num        = req_q.pf;
  assign vf_rst_vf_num        = req_q.vf;
  assign flr_completed_vf     = (vf_st_q == VF_CPL);
  assign flr_completed_pf_num = cpl_q.pf;
  assign flr_completed_vf_num = cpl_q.vf;
  assign flr_ovf_err          = ovf_q;
  assign flr_ack_timeout_err  = to_q;

  for (genvar i = 0; i < NUM_PF; i++) begin : g_pf
    pf_state_e         st_q, st_d;
    logic [PCNT_W-1:0] cnt_q, cnt_d;
    logic              act_q;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
        PF_IDLE: if (flr_active_pf[i] && !act_q) begin
          st_d  = PF_RST;
          cnt_d = '0;
        end
        // A request withdrawn mid-reset aborts without a completion.
        PF_RST: if (!flr_active_pf[i]) begin
          st_d = PF_IDLE;
        end else if (cnt_q == PCNT_W'(RST_HOLD - 1)) begin
          st_d = PF_DONE;
        end else begin
          cnt_d = cnt_q + PCNT_W'(1);
        end
        PF_DONE: if (!flr_active_pf[i]) st_d = PF_IDLE;
        default: st_d = PF_IDLE;
      endcase
    end

    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
      if (!fim_rst_n) begin
        st_q  <= PF_IDLE;
        cnt_q <= '0;
        act_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        act_q <= flr_active_pf[i];
      end
    end

    assign pf_rst_n[i]         = (st_q != PF_RST);
    assign flr_completed_pf[i] = (st_q == PF_DONE);
  end

endmodule

// File: tb/tb_pcie_flr_responder.sv
// Bench for pcie_flr_responder: directed vector table, hand-written corner sequences,
// and a randomized run against a timeline-arithmetic reference model.
module tb_pcie_flr_responder;

  localparam int NUM_PF = 2;
  localparam int PF_W   = 1;
  localparam int VF_W   = 11;
  localparam int DEPTH  = 4;
  localparam int RH     = 16;
  localparam int CG     = 32;
  localparam int AT     = 8;

  logic              clk;
  logic              rst_n;
  logic              strb;
  logic [PF_W-1:0]   rpf;
  logic [VF_W-1:0]   rvf;
  logic [NUM_PF-1:0] act;
  logic              req;
  logic [PF_W-1:0]   req_pf;
  logic [VF_W-1:0]   req_vf;
  logic              ack;
  logic [NUM_PF-1:0] pf_rst_n;
  logic              cpl_vf;
  logic [PF_W-1:0]   cpl_pfn;
  logic [VF_W-1:0]   cpl_vfn;
  logic [NUM_PF-1:0] cpl_pf;
  logic              ovf;
  logic              tmo;

  int n_tests = 0;
  int n_fail  = 0;

  pcie_flr_responder #(
    .NUM_PF(NUM_PF), .PF_WIDTH(PF_W), .VF_WIDTH(VF_W), .FIFO_DEPTH(DEPTH),
    .RST_HOLD(RH), .CPL_GAP(CG), .ACK_TIMEOUT(AT)
  ) dut (
    .fim_clk(clk), .fim_rst_n(rst_n),
    .flr_rcvd_vf(strb), .flr_rcvd_pf_num(rpf), .flr_rcvd_vf_num(rvf),
    .flr_active_pf(act),
    .vf_rst_req(req), .vf_rst_pf_num(req_pf), .vf_rst_vf_num(req_vf),
    .vf_rst_ack(ack), .pf_rst_n(pf_rst_n),
    .flr_completed_vf(cpl_vf), .flr_completed_pf_num(cpl_pfn),
    .flr_completed_vf_num(cpl_vfn), .flr_completed_pf(cpl_pf),
    .flr_ovf_err(ovf), .flr_ack_timeout_err(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1000000, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [PF_W-1:0] pf;
    logic [VF_W-1:0] vf;
    int              d;        // ack sampled on this REQ cycle; 0 = never
    int              exp_req;  // cycles vf_rst_req is high
    int              exp_lat;  // edges from strobe edge to completion strobe
    logic            exp_to;
  } vf_vec_t;

  typedef struct packed {
    logic [PF_W-1:0] pf;
    logic [VF_W-1:0] vf;
  } ent_t;

  localparam logic [63:0] RST_VEC = {32'd0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0,
                                     2'b00, 2'b11, 1'b0, 1'b0};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input logic show_nums);
    logic [PF_W-1:0] p;
    logic [VF_W-1:0] v;
    p = show_nums ? req_pf : '0;
    v = show_nums ? req_vf : '0;
    return {32'd0, req, p, v, cpl_vf, cpl_pfn, cpl_vfn, cpl_pf, pf_rst_n, ovf, tmo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    strb = 1'b0; rpf = '0; rvf = '0; act = '0; ack = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input vf_vec_t v, input int idx);
    int req_n, cpl_n, cpl_k;
    logic numok;
    logic [PF_W-1:0] cpf;
    logic [VF_W-1:0] cvf;
    req_n = 0; cpl_n = 0; cpl_k = -1; numok = 1'b1; cpf = '0; cvf = '0;
    strb = 1'b1; rpf = v.pf; rvf = v.vf;
    tick();
    strb = 1'b0; rpf = '0; rvf = '0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (req) begin
        req_n++;
        if (req_pf !== v.pf || req_vf !== v.vf) numok = 1'b0;
      end
      if (cpl_vf) begin
        cpl_n++;
        if (cpl_k < 0) begin cpl_k = k; cpf = cpl_pfn; cvf = cpl_vfn; end
      end
      ack = (v.d != 0) && (k == v.d);
    end
    check($sformatf("vec%0d_req_cycles", idx), 64'(req_n), 64'(v.exp_req));
    check($sformatf("vec%0d_cpl_latency", idx), 64'(cpl_k), 64'(v.exp_lat));
    check($sformatf("vec%0d_cpl_pulses", idx), 64'(cpl_n), 64'd1);
    check($sformatf("vec%0d_cpl_nums", idx), 64'({cpf, cvf}), 64'({v.pf, v.vf}));
    check($sformatf("vec%0d_req_nums", idx), 64'(numok), 64'd1);
    check($sformatf("vec%0d_timeout_err", idx), 64'(tmo), 64'(v.exp_to));
  endtask

  task automatic run_random(input int ncyc);
    ent_t mq[$];
    ent_t cur;
    int   free_e, cp, cd, sz;
    int   pst[NUM_PF];
    logic busy, noack, popn, accept;
    logic e_ovf, e_to, e_req, e_cpl;
    logic [PF_W-1:0] e_cpf, e_rpf;
    logic [VF_W-1:0] e_cvf, e_rvf;
    logic [NUM_PF-1:0] prev, e_rstn, e_done;
    free_e = 0; cp = 0; cd = 0; busy = 1'b0; noack = 1'b0; cur = '0;
    e_ovf = 1'b0; e_to = 1'b0; e_cpf = '0; e_cvf = '0; prev = '0;
    for (int i = 0; i < NUM_PF; i++) pst[i] = -1;
    for (int t = 0; t < ncyc; t++) begin
      tick();
      sz     = mq.size();
      popn   = (t >= free_e) && (sz > 0);
      accept = (sz < DEPTH) || popn;
      if (popn) begin
        cur    = mq.pop_front();
        cp     = t;
        noack  = ($urandom_range(0, 5) == 0);
        cd     = noack ? AT : int'($urandom_range(1, 6));
        free_e = t + cd + RH + CG + 2;
        busy   = 1'b1;
      end
      if (strb) begin
        if (accept) mq.push_back({rpf, rvf});
        else e_ovf = 1'b1;
      end
      if (busy && noack && t == cp + AT) e_to = 1'b1;
      e_req = busy && (t >= cp) && (t < cp + cd);
      e_cpl = busy && (t == cp + cd + RH);
      if (e_cpl) begin e_cpf = cur.pf; e_cvf = cur.vf; end
      e_rpf = e_req ? cur.pf : '0;
      e_rvf = e_req ? cur.vf : '0;
      for (int i = 0; i < NUM_PF; i++) begin
        if (pst[i] < 0) begin
          if (act[i] && !prev[i]) pst[i] = t;
        end else if (!act[i]) begin
          pst[i] = -1;
        end
        prev[i]   = act[i];
        e_rstn[i] = !(pst[i] >= 0 && (t - pst[i]) < RH);
        e_done[i] = (pst[i] >= 0) && ((t - pst[i]) >= RH);
      end
      check($sformatf("rand_t%0d", t), obs(e_req),
            {32'd0, e_req, e_rpf, e_rvf, e_cpl, e_cpf, e_cvf, e_done, e_rstn, e_ovf, e_to});
      ack  = busy && !noack && (t + 1 == cp + cd);
      strb = ($urandom_range(0, ((t / 400) % 2 == 0) ? 2 : 50) == 0);
      rpf  = PF_W'($urandom_range(0, 1));
      rvf  = VF_W'($urandom);
      for (int i = 0; i < NUM_PF; i++)
        if ($urandom_range(0, 24) == 0) act[i] = ~act[i];
    end
  endtask

  vf_vec_t tbl[4];
  int      got[$];
  int      last, lo_n, lo_first, lo_last, c_n, c_first, c_last, bad;
  logic    gap_ok;

  initial begin
    tbl[0] = '{pf: 1'b0, vf: 11'd5,     d: 4, exp_req: 4, exp_lat: 21, exp_to: 1'b0};
    tbl[1] = '{pf: 1'b1, vf: 11'h7FF,   d: 1, exp_req: 1, exp_lat: 18, exp_to: 1'b0};
    tbl[2] = '{pf: 1'b0, vf: 11'h123,   d: 7, exp_req: 7, exp_lat: 24, exp_to: 1'b0};
    tbl[3] = '{pf: 1'b1, vf: 11'h2AA,   d: 0, exp_req: 8, exp_lat: 25, exp_to: 1'b1};
    rst_n = 1'b1;
    do_reset();
    check("reset_state", obs(1'b1), RST_VEC);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_vec(tbl[i], i);
    end

    // Five back-to-back strobes with ack tied high: all accepted, in order, paced.
    do_reset();
    ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      strb = 1'b1; rpf = '0; rvf = VF_W'(i);
      tick();
    end
    strb = 1'b0;
    got.delete(); last = -1000; gap_ok = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (cpl_vf) begin
        got.push_back(int'(cpl_vfn));
        if (k - last < CG + RH + 2) gap_ok = 1'b0;
        last = k;
      end
    end
    check("b2b_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size(); i++) check($sformatf("b2b_order%0d", i), 64'(got[i]), 64'(i + 1));
    check("b2b_gap", 64'(gap_ok), 64'd1);
    check("b2b_no_ovf", 64'(ovf), 64'd0);

    // Ack held low: the sixth strobe finds the queue full and is dropped.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      strb = 1'b1; rpf = '0; rvf = VF_W'(i);
      tick();
      if (i == 5) check("ovf_before_6th", 64'(ovf), 64'd0);
      if (i == 6) check("ovf_after_6th", 64'(ovf), 64'd1);
    end
    strb = 1'b0;
    got.delete();
    for (int k = 0; k < 450; k++) begin
      tick();
      if (cpl_vf) got.push_back(int'(cpl_vfn));
    end
    check("ovf_cpl_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size(); i++) check($sformatf("ovf_order%0d", i), 64'(got[i]), 64'(i + 1));
    check("ovf_timeout_err", 64'(tmo), 64'd1);

    // PF0 active held 100 cycles.
    do_reset();
    act[0] = 1'b1;
    lo_n = 0; lo_first = -1; lo_last = -1; c_n = 0; c_first = -1; c_last = -1; bad = 0;
    for (int k = 0; k <= 130; k++) begin
      tick();
      if (!pf_rst_n[0]) begin lo_n++; if (lo_first < 0) lo_first = k; lo_last = k; end
      if (cpl_pf[0]) begin c_n++; if (c_first < 0) c_first = k; c_last = k; end
      if (!pf_rst_n[1] || cpl_pf[1]) bad++;
      if (k == 99) act[0] = 1'b0;
    end
    check("pf_rst_cycles", 64'(lo_n), 64'd16);
    check("pf_rst_first", 64'(lo_first), 64'd0);
    check("pf_cpl_first", 64'(c_first), 64'd16);
    check("pf_cpl_last", 64'(c_last), 64'd99);
    check("pf_cpl_cycles", 64'(c_n), 64'd84);
    check("pf1_untouched", 64'(bad), 64'd0);

    // PF0 active withdrawn 5 cycles into its reset.
    do_reset();
    act[0] = 1'b1;
    lo_n = 0; lo_last = -1; c_n = 0;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (!pf_rst_n[0]) begin lo_n++; lo_last = k; end
      if (cpl_pf[0]) c_n++;
      if (k == 4) act[0] = 1'b0;
    end
    check("pf_abort_rst_cycles", 64'(lo_n), 64'd5);
    check("pf_abort_rst_last", 64'(lo_last), 64'd4);
    check("pf_abort_no_cpl", 64'(c_n), 64'd0);

    // Async reset while the first of three requests is in HOLD.
    do_reset();
    ack = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      strb = 1'b1; rpf = 1'b1; rvf = VF_W'(i);
      tick();
    end
    strb = 1'b0; rpf = '0; rvf = '0;
    repeat (5) tick();
    ack = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", obs(1'b1), RST_VEC);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    c_n = 0; bad = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (cpl_vf) c_n++;
      if (req) bad++;
    end
    check("async_rst_no_cpl", 64'(c_n), 64'd0);
    check("async_rst_no_req", 64'(bad), 64'd0);

    do_reset();
    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
